// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the TX framer state type, used by both TX and RX paths.
package eth_pkg;

    localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DRAIN
    } tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32 (purely combinational).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/rmii_tx_framer.sv
// RMII 100 Mb/s transmit framer: preamble/SFD, payload with zero padding, FCS, IFG,
// one dibit per phy_tx_clk; underruns abort the frame and drain the rest of it.
module rmii_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_DIBITS      = 48
)(
    input  logic       phy_tx_clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] phy_tx_data,
    output logic       phy_tx_en,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam logic [5:0]  PRE_LAST = 6'(PREAMBLE_BYTES * 4 - 1);
    localparam logic [5:0]  IFG_LAST = 6'(IFG_DIBITS - 1);
    localparam logic [5:0]  FCS_LAST = 6'd15;
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);

    tx_state_e   state_q, state_d;
    logic [1:0]  dib_q, dib_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  sreg_q, sreg_d;
    logic [31:0] crc_q, crc_d;
    logic        last_q, last_d;

    logic        load;
    logic [7:0]  load_byte;
    logic [31:0] crc_next;
    logic        fetch;

    logic        s_ready_d, phy_tx_en_d, tx_busy_d, tx_done_d, tx_underrun_d;
    logic [1:0]  phy_tx_data_d;

    crc32_d8 u_crc32_d8 (
        .crc      (crc_q),
        .data     (load_byte),
        .crc_next (crc_next)
    );

    // State and counters describe the dibit on the wire; outputs are registered
    // from the next-state values so they line up with it.
    always_ff @(posedge phy_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dib_q       <= '0;
            cnt_q       <= '0;
            byte_cnt_q  <= '0;
            sreg_q      <= '0;
            crc_q       <= CRC32_INIT;
            last_q      <= 1'b0;
            s_ready     <= 1'b0;
            phy_tx_data <= '0;
            phy_tx_en   <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            dib_q       <= dib_d;
            cnt_q       <= cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sreg_q      <= sreg_d;
            crc_q       <= crc_d;
            last_q      <= last_d;
            s_ready     <= s_ready_d;
            phy_tx_data <= phy_tx_data_d;
            phy_tx_en   <= phy_tx_en_d;
            tx_busy     <= tx_busy_d;
            tx_done     <= tx_done_d;
            tx_underrun <= tx_underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dib_d      = dib_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        sreg_d     = sreg_q;
        crc_d      = crc_q;
        last_d     = last_q;
        load       = 1'b0;
        load_byte  = 8'h00;
        fetch      = (dib_q == 2'd3) &&
                     ((state_q == ST_SFD) || ((state_q == ST_DATA) && !last_q));

        unique case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                end
            end
            ST_PRE: begin
                crc_d      = CRC32_INIT;
                byte_cnt_d = '0;
                last_d     = 1'b0;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    dib_d   = '0;
                    sreg_d  = SFD_BYTE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_SFD, ST_DATA, ST_PAD: begin
                if (dib_q != 2'd3) begin
                    dib_d  = dib_q + 2'd1;
                    sreg_d = sreg_q >> 2;
                end else if (fetch) begin
                    if (s_valid) begin
                        state_d   = ST_DATA;
                        load      = 1'b1;
                        load_byte = s_data;
                        last_d    = s_last;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (byte_cnt_q < MIN_CNT) begin
                    state_d = ST_PAD;
                    load    = 1'b1;
                end else begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end
            end
            ST_FCS: begin
                crc_d = crc_q >> 2;
                if (cnt_q == FCS_LAST) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = s_valid ? ST_PRE : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            dib_d  = '0;
            sreg_d = load_byte;
            crc_d  = crc_next;
            if (byte_cnt_q != '1) begin
                byte_cnt_d = byte_cnt_q + 11'd1;
            end
        end
    end

    always_comb begin
        phy_tx_en_d   = 1'b0;
        phy_tx_data_d = 2'b00;
        s_ready_d     = 1'b0;
        tx_busy_d     = (state_d != ST_IDLE);
        tx_done_d     = 1'b0;
        tx_underrun_d = fetch && !s_valid;

        unique case (state_d)
            ST_PRE: begin
                phy_tx_en_d   = 1'b1;
                phy_tx_data_d = PREAMBLE_DIBIT;
            end
            ST_SFD: begin
                phy_tx_en_d   = 1'b1;
                phy_tx_data_d = sreg_d[1:0];
                s_ready_d     = (dib_d == 2'd3);
            end
            ST_DATA: begin
                phy_tx_en_d   = 1'b1;
                phy_tx_data_d = sreg_d[1:0];
                s_ready_d     = (dib_d == 2'd3) && !last_d;
            end
            ST_PAD: begin
                phy_tx_en_d   = 1'b1;
                phy_tx_data_d = sreg_d[1:0];
            end
            ST_FCS: begin
                phy_tx_en_d   = 1'b1;
                phy_tx_data_d = ~crc_d[1:0];
                tx_done_d     = (cnt_d == FCS_LAST);
            end
            ST_DRAIN: s_ready_d = 1'b1;
            default: ;
        endcase
    end

endmodule
